// File: rtl/prefetch_fifo_sc.sv
// Single-clock FIFO: RAM core feeding a chain of registered look-ahead stages.
// Every stage and its valid bit are visible at once so a consumer can peek ahead without popping.
module prefetch_fifo_sc #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 1024,
  parameter int LOOKAHEAD     = 3,
  parameter int PROG_FULL_TH  = DEPTH - 16,
  parameter int PROG_EMPTY_TH = 4
) (
  input  logic                                 data_clk,
  input  logic                                 data_rst,
  input  logic [DATA_W-1:0]                    wr_data_i,
  input  logic                                 wr_en_i,
  output logic                                 full_o,
  output logic                                 prog_full_o,
  output logic                                 overflow_o,
  output logic [DATA_W*LOOKAHEAD-1:0]          data_o,
  output logic [LOOKAHEAD-1:0]                 data_valid_o,
  input  logic                                 read_i,
  output logic                                 empty_o,
  output logic                                 prog_empty_o,
  output logic                                 underflow_o,
  input  logic                                 clear_err_i,
  output logic [$clog2(DEPTH+LOOKAHEAD+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + LOOKAHEAD + 1);
  localparam int VW = $clog2(LOOKAHEAD + 1);
  localparam logic [VW-1:0] LA_V    = VW'(LOOKAHEAD);
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [CW-1:0] PF_TH   = CW'(PROG_FULL_TH);
  localparam logic [CW-1:0] PE_TH   = CW'(PROG_EMPTY_TH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     wr_vis_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [VW-1:0]     nvalid_r;

  logic                        wr_acc_s;
  logic                        pop_s;
  logic                        issue_s;
  logic [DATA_W-1:0]           ram_word_s;
  logic [PW-1:0]               wr_ptr_next_s;
  logic [PW-1:0]               rd_ptr_next_s;
  logic [PW-1:0]               ram_cnt_next_s;
  logic [CW-1:0]               count_next_s;
  logic [VW-1:0]               nvalid_shift_s;
  logic [VW-1:0]               nvalid_next_s;
  logic [DATA_W*LOOKAHEAD-1:0] shifted_s;
  logic [DATA_W*LOOKAHEAD-1:0] data_next_s;
  logic [LOOKAHEAD-1:0]        valid_next_s;

  assign wr_acc_s   = wr_en_i & ~full_o;
  assign pop_s      = read_i & data_valid_o[0];
  assign ram_word_s = mem_r[rd_ptr_r[AW-1:0]];
  // The read side sees writes one cycle late (wr_vis_r), giving a fixed 2-cycle fall-through.
  assign issue_s    = (wr_vis_r != rd_ptr_r) && ((nvalid_r != LA_V) || pop_s);

  assign wr_ptr_next_s  = wr_ptr_r + PW'(wr_acc_s);
  assign rd_ptr_next_s  = rd_ptr_r + PW'(issue_s);
  assign ram_cnt_next_s = wr_ptr_next_s - rd_ptr_next_s;
  assign count_next_s   = count_o + CW'(wr_acc_s) - CW'(pop_s);
  assign nvalid_shift_s = nvalid_r - VW'(pop_s);
  assign nvalid_next_s  = nvalid_shift_s + VW'(issue_s);
  assign shifted_s      = data_o >> DATA_W;

  // Next stage contents: shift on pop, RAM word lands in the lowest free stage.
  always_comb begin
    data_next_s  = data_o;
    valid_next_s = {LOOKAHEAD{1'b0}};
    for (int k = 0; k < LOOKAHEAD; k++) begin
      if (issue_s && (VW'(k) == nvalid_shift_s)) begin
        data_next_s[k*DATA_W +: DATA_W] = ram_word_s;
      end else if (pop_s) begin
        data_next_s[k*DATA_W +: DATA_W] = shifted_s[k*DATA_W +: DATA_W];
      end else begin
        data_next_s[k*DATA_W +: DATA_W] = data_o[k*DATA_W +: DATA_W];
      end
      valid_next_s[k] = (VW'(k) < nvalid_next_s);
    end
  end

  // Word storage; left unreset because the pointers alone decide which entries are live.
  always_ff @(posedge data_clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointers, stage chain, occupancy and status flags.
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      wr_ptr_r     <= {PW{1'b0}};
      wr_vis_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      nvalid_r     <= {VW{1'b0}};
      data_o       <= {(DATA_W*LOOKAHEAD){1'b0}};
      data_valid_o <= {LOOKAHEAD{1'b0}};
      count_o      <= {CW{1'b0}};
      empty_o      <= 1'b1;
      prog_empty_o <= 1'b1;
      full_o       <= 1'b0;
      prog_full_o  <= 1'b0;
      overflow_o   <= 1'b0;
      underflow_o  <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_next_s;
      wr_vis_r     <= wr_ptr_r;
      rd_ptr_r     <= rd_ptr_next_s;
      nvalid_r     <= nvalid_next_s;
      data_o       <= data_next_s;
      data_valid_o <= valid_next_s;
      count_o      <= count_next_s;
      empty_o      <= (count_next_s == {CW{1'b0}});
      prog_empty_o <= (count_next_s <= PE_TH);
      full_o       <= (ram_cnt_next_s == DEPTH_V);
      prog_full_o  <= (count_next_s >= PF_TH);
      // A new error event outranks a same-cycle clear.
      overflow_o   <= (wr_en_i & full_o) | (overflow_o & ~clear_err_i);
      underflow_o  <= (read_i & ~data_valid_o[0]) | (underflow_o & ~clear_err_i);
    end
  end

endmodule

// File: tb/tb_prefetch_fifo_sc.sv
// Directed bench for prefetch_fifo_sc: vector table for fill/drain/underflow,
// hand sequences for full/overflow, random in-order traffic, steady state and mid-run reset.
module tb_prefetch_fifo_sc;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LA    = 3;
  localparam int PFT   = 12;
  localparam int PET   = 2;
  localparam int CW    = $clog2(DEPTH + LA + 1);

  logic          data_clk = 1'b0;
  logic          data_rst;
  logic [DW-1:0] wr_data_i;
  logic          wr_en_i;
  logic          full_o, prog_full_o, overflow_o;
  logic [DW*LA-1:0] data_o;
  logic [LA-1:0] data_valid_o;
  logic          read_i;
  logic          empty_o, prog_empty_o, underflow_o;
  logic          clear_err_i;
  logic [CW-1:0] count_o;

  prefetch_fifo_sc #(
    .DATA_W(DW), .DEPTH(DEPTH), .LOOKAHEAD(LA),
    .PROG_FULL_TH(PFT), .PROG_EMPTY_TH(PET)
  ) dut (
    .data_clk(data_clk), .data_rst(data_rst),
    .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
    .full_o(full_o), .prog_full_o(prog_full_o), .overflow_o(overflow_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .read_i(read_i),
    .empty_o(empty_o), .prog_empty_o(prog_empty_o), .underflow_o(underflow_o),
    .clear_err_i(clear_err_i), .count_o(count_o)
  );

  always #5 data_clk = ~data_clk;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        clr;
    int          cnt;
    logic [2:0]  dv;
    logic [31:0] head;
    logic        uf;
  } vec_t;

  vec_t        tbl [14];
  int          errors = 0;
  int          checks = 0;
  int          mcnt;
  logic        rnd_wr, rnd_rd;
  logic [31:0] exp_head;
  logic [31:0] q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge data_clk);
    #1;
  endtask

  task automatic chk_occ(input string tag, input int cnt);
    chk({tag, " count"}, 32'(count_o), cnt);
    chk({tag, " empty"}, 32'(empty_o), 32'(cnt == 0));
    chk({tag, " prog_empty"}, 32'(prog_empty_o), 32'(cnt <= PET));
    chk({tag, " prog_full"}, 32'(prog_full_o), 32'(cnt >= PFT));
  endtask

  task automatic reset_dut(input string tag);
    data_rst = 1'b1; wr_en_i = 1'b0; read_i = 1'b0; clear_err_i = 1'b0; wr_data_i = 32'h0;
    step();
    data_rst = 1'b0;
    chk_occ(tag, 0);
    chk({tag, " valid"}, 32'(data_valid_o), 32'h0);
    chk({tag, " data"}, data_o[31:0] | data_o[63:32] | data_o[95:64], 32'h0);
    chk({tag, " full"}, 32'(full_o), 32'h0);
    chk({tag, " overflow"}, 32'(overflow_o), 32'h0);
    chk({tag, " underflow"}, 32'(underflow_o), 32'h0);
  endtask

  task automatic wait_head(input string tag, input int budget);
    int n = 0;
    while (!data_valid_o[0] && n < budget) begin
      step();
      n++;
    end
    chk({tag, " head valid within budget"}, 32'(data_valid_o[0]), 32'h1);
  endtask

  initial begin
    data_rst = 1'b0; wr_en_i = 1'b0; read_i = 1'b0; clear_err_i = 1'b0; wr_data_i = 32'h0;
    reset_dut("reset");

    //          wr    din     rd    clr   cnt dv      head    uf
    tbl[0]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1, 3'b000, 32'h00, 1'b0};
    tbl[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 2, 3'b000, 32'h00, 1'b0};
    tbl[2]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 3, 3'b001, 32'hA0, 1'b0};
    tbl[3]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 4, 3'b011, 32'hA0, 1'b0};
    tbl[4]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 5, 3'b111, 32'hA0, 1'b0};
    tbl[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 5, 3'b111, 32'hA0, 1'b0};
    tbl[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 4, 3'b111, 32'hA1, 1'b0};
    tbl[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 3, 3'b111, 32'hA2, 1'b0};
    tbl[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 2, 3'b011, 32'hA3, 1'b0};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 3'b001, 32'hA4, 1'b0};
    tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 3'b000, 32'h00, 1'b0};
    tbl[11] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 3'b000, 32'h00, 1'b1};
    tbl[12] = '{1'b0, 32'h00, 1'b1, 1'b1, 0, 3'b000, 32'h00, 1'b1};
    tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 0, 3'b000, 32'h00, 1'b0};

    for (int i = 0; i < 14; i++) begin
      wr_en_i = tbl[i].wr; wr_data_i = tbl[i].din; read_i = tbl[i].rd; clear_err_i = tbl[i].clr;
      step();
      chk_occ($sformatf("vec%0d", i), tbl[i].cnt);
      chk($sformatf("vec%0d valid", i), 32'(data_valid_o), 32'(tbl[i].dv));
      chk($sformatf("vec%0d underflow", i), 32'(underflow_o), 32'(tbl[i].uf));
      if (tbl[i].dv[0]) chk($sformatf("vec%0d head", i), data_o[31:0], tbl[i].head);
      if (i == 5) begin
        chk("vec5 stage1", data_o[63:32], 32'hA1);
        chk("vec5 stage2", data_o[95:64], 32'hA2);
      end
    end
    wr_en_i = 1'b0; read_i = 1'b0; clear_err_i = 1'b0;

    // Fill to total capacity, then overflow and clear.
    for (int i = 0; i < 19; i++) begin
      wr_en_i = 1'b1; wr_data_i = 32'hB0 + 32'(i);
      step();
      chk_occ($sformatf("fill%0d", i), i + 1);
      chk($sformatf("fill%0d full", i), 32'(full_o), 32'(i == 18));
    end
    wr_data_i = 32'hDEAD;
    step();
    chk("ovf overflow", 32'(overflow_o), 32'h1);
    chk("ovf count", 32'(count_o), 32'd19);
    chk("ovf full", 32'(full_o), 32'h1);
    wr_en_i = 1'b0; clear_err_i = 1'b1;
    step();
    clear_err_i = 1'b0;
    chk("clr overflow", 32'(overflow_o), 32'h0);

    for (int n = 0; n < 19; n++) begin
      chk($sformatf("drain%0d valid", n), 32'(data_valid_o[0]), 32'h1);
      chk($sformatf("drain%0d head", n), data_o[31:0], 32'hB0 + 32'(n));
      read_i = 1'b1;
      step();
      chk_occ($sformatf("drain%0d", n), 18 - n);
      if (n == 0) chk("drain0 full", 32'(full_o), 32'h0);
    end
    read_i = 1'b0;

    // Random traffic across several pointer wraps.
    mcnt = 0;
    for (int c = 0; c < 200; c++) begin
      rnd_wr = ($urandom_range(0, 1) == 1) && (mcnt < 10);
      rnd_rd = data_valid_o[0];
      wr_en_i = rnd_wr; wr_data_i = $urandom; read_i = rnd_rd;
      if (rnd_rd) begin
        exp_head = (q.size() > 0) ? q.pop_front() : ~data_o[31:0];
        chk($sformatf("rand%0d head", c), data_o[31:0], exp_head);
      end
      if (rnd_wr) q.push_back(wr_data_i);
      mcnt = mcnt + int'(rnd_wr) - int'(rnd_rd);
      step();
      chk($sformatf("rand%0d count", c), 32'(count_o), mcnt);
    end
    wr_en_i = 1'b0; read_i = 1'b0;

    // Steady state at 8 words: simultaneous write and pop with no bubbles.
    reset_dut("reset2");
    q.delete();
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1; wr_data_i = 32'hC0 + 32'(i); q.push_back(wr_data_i);
      step();
    end
    wr_en_i = 1'b0;
    for (int n = 0; n < 10 && data_valid_o != 3'b111; n++) step();
    chk("steady start valid", 32'(data_valid_o), 32'h7);
    chk("steady start count", 32'(count_o), 32'd8);
    for (int i = 0; i < 50; i++) begin
      wr_en_i = 1'b1; wr_data_i = 32'hD00 + 32'(i); read_i = 1'b1;
      exp_head = q.pop_front();
      q.push_back(wr_data_i);
      chk($sformatf("steady%0d head", i), data_o[31:0], exp_head);
      step();
      chk($sformatf("steady%0d count", i), 32'(count_o), 32'd8);
      chk($sformatf("steady%0d valid", i), 32'(data_valid_o), 32'h7);
    end
    read_i = 1'b0;

    // Two more writes reach 10, then reset mid-run.
    wr_data_i = 32'hE0;
    step();
    wr_data_i = 32'hE1;
    step();
    wr_en_i = 1'b0;
    chk("pre-reset count", 32'(count_o), 32'd10);
    reset_dut("midreset");
    wr_en_i = 1'b1; wr_data_i = 32'h55;
    step();
    wr_en_i = 1'b0;
    wait_head("post-reset", 5);
    chk("post-reset head", data_o[31:0], 32'h55);
    chk("post-reset count", 32'(count_o), 32'd1);
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    step();
    step();
    chk("post-reset drained valid", 32'(data_valid_o), 32'h0);
    chk("post-reset drained count", 32'(count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_fifo_sc.md
Name: prefetch_fifo_sc

Overview:
- Single-clock, parametrised FIFO with a configurable chain of look-ahead output stages.
- Successor to the fixed 32-bit, 3-deep (decoupler/middle/top) read-side buffering. All look-ahead words and their valid flags are exposed at once, so downstream packers can peek ahead without popping.
- Adds occupancy count, programmable thresholds, and sticky overflow/underflow flags.
- Sits between the TDC event stream and the packet formatter, in the data_clk domain.

Parameters:
- DATA_W, 32: word width.
- DEPTH, 1024: RAM words; power of 2, minimum 4.
- LOOKAHEAD, 3: number of output stages, range 1..4.
- PROG_FULL_TH, DEPTH-16: prog_full_o asserts when count_o >= this value.
- PROG_EMPTY_TH, 4: prog_empty_o asserts when count_o <= this value.

Ports:
- data_clk  in  1  clock
- data_rst  in  1  synchronous, active-high reset
- wr_data_i  in  DATA_W  write word
- wr_en_i  in  1  write strobe
- full_o  out  1  RAM holds DEPTH words
- prog_full_o  out  1  occupancy >= PROG_FULL_TH
- overflow_o  out  1  sticky: write attempted while full_o=1
- data_o  out  DATA_W*LOOKAHEAD  stage k in bits [k*DATA_W +: DATA_W]; stage 0 is the head
- data_valid_o  out  LOOKAHEAD  bit k = stage k holds a word
- read_i  in  1  pop stage 0
- empty_o  out  1  no word in RAM, in flight, or in any stage
- prog_empty_o  out  1  occupancy <= PROG_EMPTY_TH
- underflow_o  out  1  sticky: read_i while data_valid_o[0]=0
- clear_err_i  in  1  clears overflow_o and underflow_o
- count_o  out  $clog2(DEPTH+LOOKAHEAD+1)  total words held

Behaviour:
- Reset (data_rst=1 at the clock edge), all outputs registered:
  - data_valid_o=0, data_o=0, count_o=0, empty_o=1, prog_empty_o=1.
  - full_o=0, prog_full_o=0, overflow_o=0, underflow_o=0.
  - Pointers and in-flight flag cleared. Reset mid-operation discards all contents; no pre-reset word ever appears on data_o.
- Write:
  - Accepted when wr_en_i=1 and full_o=0; the word enters the RAM.
  - When full_o=1 the write is dropped, overflow_o is set and count_o is unchanged.
  - A simultaneous read does not rescue a write while full_o=1.
- RAM read:
  - Registered, 1-cycle latency.
  - Issued in cycle t when the RAM is non-empty and (valid stages + in-flight − pop_t) < LOOKAHEAD.
  - The returned word lands at t+1 in the lowest stage left free after that cycle's pop.
  - At most one RAM read in flight.
- Stage chain:
  - On a pop (read_i=1 and data_valid_o[0]=1), stages shift toward stage 0 by one in the same edge.
  - data_valid_o is always a thermometer code: contiguous ones from bit 0.
  - Data in invalid stages is don't-care; the bench must ignore it.
- Underflow: read_i while data_valid_o[0]=0 is ignored and sets underflow_o.
- Latency: a write into an empty FIFO at edge t gives data_valid_o[0]=1 after edge t+2 (fixed 2 cycles, no bypass).
- Throughput: sustained 1 write + 1 read per cycle with no bubbles once stage 0 is valid.
- count_o:
  - count_o = RAM words + in-flight + valid stages.
  - +1 per accepted write, −1 per pop, net 0 when both occur; updated at the same edge.
- full_o: registered, equals (RAM words == DEPTH). Total capacity is DEPTH+LOOKAHEAD.
- Flags:
  - prog_full_o and prog_empty_o are registered from the next-state count, so they are coincident with count_o.
  - empty_o = (count_o == 0).
- Error flags:
  - clear_err_i=1 clears both sticky flags.
  - If an error event and clear_err_i occur in the same cycle, set wins.
- Pointer wrap: binary pointers one bit wider than log2(DEPTH); full/empty are distinguished by the MSB. Wrap at DEPTH is seamless.

Test Plan (DATA_W=32, DEPTH=16, LOOKAHEAD=3, PROG_FULL_TH=12, PROG_EMPTY_TH=2):
- Reset; write 0xA0..0xA4 on 5 consecutive cycles, read_i=0:
  - data_valid_o[0] rises 2 cycles after the first write.
  - Settles to data_valid_o=3'b111, stages = A0/A1/A2, count_o=5, prog_empty_o=0.
- Write 19 words, no reads:
  - full_o=1 after the 19th write; a 20th write sets overflow_o=1 and leaves count_o=19.
  - Every word thereafter reads out in order.
  - clear_err_i for 1 cycle drops overflow_o to 0.
- Run 200 cycles with random wr_en_i (~50%) and read_i=data_valid_o[0]:
  - Output sequence equals input sequence across multiple pointer wraps.
  - count_o matches the scoreboard every cycle.
- Steady state with count_o=8, then write and pop in the same cycle for 50 cycles:
  - count_o stays at 8, data_valid_o stays 3'b111, with no bubbles.
- read_i=1 on an empty FIFO:
  - underflow_o=1, count_o=0, data_valid_o=0.
  - Underflow and clear_err_i in the same cycle leaves underflow_o=1.
- With count_o=10, assert data_rst for 1 cycle:
  - Next cycle: count_o=0, empty_o=1, data_valid_o=0, all flags 0.
  - New word 0x55 then emerges as the first output.
- Threshold crossings:
  - prog_full_o toggles at count_o 11→12 and 12→11.
  - prog_empty_o toggles at count_o 2→3 and 3→2.
